exe_div_ctrl: RTL and testbench
===============================

EXE_DIV_CTRL -- requirements
Module: exe_div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width; only 32 is verified.
REQ-002 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port div_req  in  1  EXE-stage request; valid only with exactly one div_op bit set.
REQ-005 SHALL have port div_op  in  4  one-hot {div_w, mod_w, div_wu, mod_wu}, same order as mul_div_op[3:0] on the ID-to-EXE bus.
REQ-006 SHALL have port src1  in  DW  dividend (rj value).
REQ-007 SHALL have port src2  in  DW  divisor (rk value).
REQ-008 SHALL have port flush  in  1  pipeline cancel; aborts any operation in flight.
REQ-009 SHALL have port out_allowin  in  1  downstream (MEM) accepts the result this cycle.
REQ-010 SHALL have port busy  out  1  operation accepted and not yet consumed; EXE uses ~busy|res_valid for ready_go.
REQ-011 SHALL have port res_valid  out  1  result valid.
REQ-012 SHALL have port result  out  DW  quotient or remainder per latched op.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-014 Accept: in IDLE with div_req=1 and flush=0, SHALL latch op, signs, |src1|, |src2| (absolute values only for div_w/mod_w), clear the 5-bit counter, enter CALC.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles (counter 0..31), then enter FIX.
REQ-016 FIX SHALL apply sign correction in one cycle: quotient negated when signs differ; remainder takes dividend sign; unsigned ops uncorrected; then enter DONE.
REQ-017 res_valid SHALL rise exactly 34 cycles after the accepting edge and stay high with result stable until out_allowin=1.
REQ-018 DONE with out_allowin=1 SHALL return to IDLE next cycle; a new request SHALL NOT be accepted in that same cycle (one bubble minimum).
REQ-019 busy SHALL equal (state != IDLE); res_valid SHALL equal (state == DONE).
REQ-020 div_req while not IDLE SHALL be ignored; inputs are sampled only at accept.
REQ-021 Divisor zero SHALL yield quotient 32'hFFFFFFFF and remainder = src1 for all four ops, no sign fixup.
REQ-022 Overflow 0x80000000 div_w 0xFFFFFFFF SHALL yield 0x80000000; mod_w SHALL yield 0.
REQ-023 flush=1 in any state SHALL force IDLE next cycle, res_valid=0 next cycle; flush wins over simultaneous div_req and out_allowin.
REQ-024 Internal remainder SHALL be 33 bits wide; all arithmetic modulo 2^32 at output.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, busy 0, res_valid 0, result 0, latched operands 0 on the next edge.
REQ-026 reset mid-operation SHALL discard it with no residual output; reset has priority over flush and div_req.

Structure
REQ-027 FSM state encoding and div_op bit indices SHALL live in the shared cpu package, beside the ID-to-EXE bus length constants.
REQ-028 The single-iteration step (33-bit compare/subtract, quotient bit, shifted remainder) SHALL be the combinational sub-module div_step; the FSM, counter, and sign fixup stay in exe_div_ctrl.

Verification
REQ-029 100 div_w 7 -> res_valid at accept+34, result 14; hold with out_allowin=0 for 5 cycles keeps 14 stable.
REQ-030 -100 (0xFFFFFF9C) mod_w 7 -> 0xFFFFFFFE; 0xFFFFFFFF div_wu 2 -> 0x7FFFFFFF; 7 mod_wu 0xFFFFFFFF -> 7.
REQ-031 0x12345678 div_w 0 -> 0xFFFFFFFF; mod_wu 0 -> 0x12345678.
REQ-032 0x80000000 div_w 0xFFFFFFFF -> 0x80000000; mod_w -> 0.
REQ-033 Accept, flush at accept+10 -> IDLE next cycle, busy 0, no res_valid; new req after flush gives correct result at its own accept+34.
REQ-034 Back-to-back: consume with out_allowin=1 while div_req=1 -> second accept one cycle later, both results correct.

Source files
------------

// File: rtl/exe_div_ctrl_pkg.sv
// rtl/exe_div_ctrl_pkg.sv - shared cpu constants for the EXE-stage divider
// Holds the divider FSM encoding, the div_op one-hot bit positions and the
// ID-to-EXE bus field width they are carried in.
package exe_div_ctrl_pkg;

   // Width of the mul_div_op field on the ID-to-EXE bus; the divider uses bits [3:0].
   localparam int MUL_DIV_OP_WD = 4;

   // div_op one-hot order matches mul_div_op[3:0]: {div_w, mod_w, div_wu, mod_wu}
   localparam int DIV_W_BIT  = 3;
   localparam int MOD_W_BIT  = 2;
   localparam int DIV_WU_BIT = 1;
   localparam int MOD_WU_BIT = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/exe_div_ctrl_if.sv
// rtl/exe_div_ctrl_if.sv - EXE-stage to divider request/result bundle
// master: EXE stage (drives div_req, div_op, src1, src2, flush, out_allowin)
// slave : divider   (drives busy, res_valid, result)
interface exe_div_ctrl_if
   import exe_div_ctrl_pkg::*;
#(
   parameter int DW = 32
);
   logic                     div_req;
   logic [MUL_DIV_OP_WD-1:0] div_op;
   logic [DW-1:0]            src1;
   logic [DW-1:0]            src2;
   logic                     flush;
   logic                     out_allowin;
   logic                     busy;
   logic                     res_valid;
   logic [DW-1:0]            result;

   modport master (
      output div_req, div_op, src1, src2, flush, out_allowin,
      input  busy, res_valid, result
   );

   modport slave (
      input  div_req, div_op, src1, src2, flush, out_allowin,
      output busy, res_valid, result
   );
endinterface

// File: rtl/exe_div_ctrl_div_step.sv
// rtl/exe_div_ctrl_div_step.sv - one restoring shift-subtract iteration
// rem_in      : current partial remainder (DW+1 bits)
// dividend_bit: next dividend bit shifted into the remainder
// divisor     : divisor magnitude
// rem_out     : partial remainder after this iteration
// q_bit       : quotient bit produced by this iteration
module div_step #(
   parameter int DW = 32
) (
   input  logic [DW:0]   rem_in,
   input  logic          dividend_bit,
   input  logic [DW-1:0] divisor,
   output logic [DW:0]   rem_out,
   output logic          q_bit
);
   logic [DW:0] rem_sh;
   logic [DW:0] rem_sub;

   assign rem_sh  = {rem_in[DW-1:0], dividend_bit};
   assign rem_sub = rem_sh - {1'b0, divisor};
   // A set rem_in[DW] means the true shifted value overflows DW+1 bits, so it
   // is certainly at least the divisor.
   assign q_bit   = rem_in[DW] | (rem_sh >= {1'b0, divisor});
   assign rem_out = q_bit ? rem_sub : rem_sh;
endmodule

// File: rtl/exe_div_ctrl.sv
// rtl/exe_div_ctrl.sv - multi-cycle signed/unsigned divider for the EXE stage
// clk   : clock, rising edge
// reset : synchronous active-high reset
// div   : slave side of exe_div_ctrl_if (request, operands, flush, out_allowin
//         in; busy, res_valid, result out)
// Flow: IDLE -> CALC (32 steps) -> FIX (sign correction) -> DONE (hold result).
module exe_div_ctrl
   import exe_div_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   exe_div_ctrl_if.slave div
);
   localparam int CW = $clog2(DW);

   div_state_t               state;
   logic [CW-1:0]            cnt;
   logic [MUL_DIV_OP_WD-1:0] op;
   logic                     neg_q;
   logic                     neg_r;
   logic                     div_zero;
   logic [DW:0]              rem;
   logic [DW-1:0]            quo;
   logic [DW-1:0]            dvs;
   logic [DW-1:0]            result_q;

   logic          is_signed;
   logic          a_neg;
   logic          b_neg;
   logic [DW:0]   step_rem;
   logic          step_q;

   // Magnitudes are taken only for the signed ops.
   assign is_signed = div.div_op[DIV_W_BIT] | div.div_op[MOD_W_BIT];
   assign a_neg     = is_signed & div.src1[DW-1];
   assign b_neg     = is_signed & div.src2[DW-1];

   // quo starts as the dividend and shifts left each step: its MSB feeds the
   // remainder while the new quotient bit enters at the LSB.
   div_step #(.DW(DW)) u_step (
      .rem_in      (rem),
      .dividend_bit(quo[DW-1]),
      .divisor     (dvs),
      .rem_out     (step_rem),
      .q_bit       (step_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         result_q <= '0;
      end else if (div.flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (div.div_req) begin
                  op       <= div.div_op;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= (div.src2 == '0);
                  quo      <= a_neg ? -div.src1 : div.src1;
                  dvs      <= b_neg ? -div.src2 : div.src2;
                  rem      <= '0;
                  cnt      <= '0;
                  state    <= S_CALC;
               end
            end
            S_CALC: begin
               rem <= step_rem;
               quo <= {quo[DW-2:0], step_q};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DW - 1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               // A zero divisor already yields an all-ones quotient and a
               // remainder of |src1|; the dividend-sign fixup on the remainder
               // restores src1 exactly, so only the quotient is forced.
               if (op[DIV_W_BIT] | op[DIV_WU_BIT]) begin
                  if (div_zero) begin
                     result_q <= '1;
                  end else begin
                     result_q <= neg_q ? -quo : quo;
                  end
               end else if (op[MOD_W_BIT] | op[MOD_WU_BIT]) begin
                  result_q <= neg_r ? -rem[DW-1:0] : rem[DW-1:0];
               end else begin
                  result_q <= '0;
               end
               state <= S_DONE;
            end
            S_DONE: begin
               if (div.out_allowin) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign div.busy      = (state != S_IDLE);
   assign div.res_valid = (state == S_DONE);
   assign div.result    = result_q;
endmodule

// File: tb/tb_exe_div_ctrl.sv
// tb/tb_exe_div_ctrl.sv - directed self-checking bench for exe_div_ctrl
module tb_exe_div_ctrl;
   localparam logic [3:0] OP_DIV_W  = 4'b1000;
   localparam logic [3:0] OP_MOD_W  = 4'b0100;
   localparam logic [3:0] OP_DIV_WU = 4'b0010;
   localparam logic [3:0] OP_MOD_WU = 4'b0001;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   exe_div_ctrl_if #(.DW(32)) dif ();

   exe_div_ctrl #(.DW(32)) dut (
      .clk  (clk),
      .reset(reset),
      .div  (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents a request for one cycle; returns #1 after the accepting edge.
   task automatic do_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dif.div_req = 1'b1;
      dif.div_op  = op;
      dif.src1    = a;
      dif.src2    = b;
      @(posedge clk);
      #1;
      dif.div_req = 1'b0;
      check("busy_after_accept", 32'(dif.busy), 32'd1);
   endtask

   // Called #1 after edge number 'skip' following the accept edge. The accept
   // cycle counts as cycle 0, so cycle 34 starts after the 33rd edge.
   task automatic wait_done(input string tag, input int skip, input logic [31:0] exp);
      for (int i = skip + 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         if (i == 32) check("not_yet_valid", 32'(dif.res_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      check("res_valid_at_34", 32'(dif.res_valid), 32'd1);
      check(tag, dif.result, exp);
   endtask

   task automatic consume();
      dif.out_allowin = 1'b1;
      @(posedge clk);
      #1;
      dif.out_allowin = 1'b0;
      check("idle_after_consume", 32'(dif.busy), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      do_accept(op, a, b);
      wait_done(tag, 0, exp);
      consume();
   endtask

   initial begin
      int vcnt;
      n_checks        = 0;
      n_pass          = 0;
      reset           = 1'b1;
      dif.div_req     = 1'b0;
      dif.div_op      = 4'b0000;
      dif.src1        = 32'd0;
      dif.src2        = 32'd0;
      dif.flush       = 1'b0;
      dif.out_allowin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(dif.busy), 32'd0);
      check("reset_res_valid", 32'(dif.res_valid), 32'd0);
      check("reset_result", dif.result, 32'd0);
      reset = 1'b0;

      // 100 / 7 = 14, then hold without out_allowin
      do_accept(OP_DIV_W, 32'd100, 32'd7);
      wait_done("div_w_100_7", 0, 32'd14);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(dif.res_valid), 32'd1);
         check("hold_result", dif.result, 32'd14);
      end
      consume();

      run_op("mod_w_m100_7",   OP_MOD_W,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE);
      run_op("div_w_m100_7",   OP_DIV_W,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2);
      run_op("div_wu_max_2",   OP_DIV_WU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF);
      run_op("mod_wu_7_max",   OP_MOD_WU, 32'd7,        32'hFFFFFFFF, 32'd7);
      run_op("div_w_by0",      OP_DIV_W,  32'h12345678, 32'd0,        32'hFFFFFFFF);
      run_op("mod_wu_by0",     OP_MOD_WU, 32'h12345678, 32'd0,        32'h12345678);
      run_op("div_w_neg_by0",  OP_DIV_W,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
      run_op("mod_w_neg_by0",  OP_MOD_W,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
      run_op("div_w_ovf",      OP_DIV_W,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      run_op("mod_w_ovf",      OP_MOD_W,  32'h80000000, 32'hFFFFFFFF, 32'd0);

      // A request while busy is ignored: 50/5 must still come out
      do_accept(OP_DIV_WU, 32'd50, 32'd5);
      @(negedge clk);
      dif.div_req = 1'b1;
      dif.div_op  = OP_DIV_WU;
      dif.src1    = 32'd999;
      dif.src2    = 32'd1;
      @(posedge clk);
      #1;
      dif.div_req = 1'b0;
      wait_done("ignore_busy_req", 1, 32'd10);
      consume();

      // Flush mid-calculation, then a fresh request
      do_accept(OP_DIV_W, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      dif.flush = 1'b1;
      @(posedge clk);
      #1;
      dif.flush = 1'b0;
      check("flush_busy", 32'(dif.busy), 32'd0);
      check("flush_res_valid", 32'(dif.res_valid), 32'd0);
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dif.res_valid || dif.busy) vcnt++;
      end
      check("flush_quiet", 32'(vcnt), 32'd0);
      run_op("after_flush", OP_DIV_W, 32'd1000, 32'd3, 32'd333);

      // Reset mid-operation clears the held result
      do_accept(OP_DIV_WU, 32'd77, 32'd7);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_mid_busy", 32'(dif.busy), 32'd0);
      check("rst_mid_result", dif.result, 32'd0);
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dif.res_valid) vcnt++;
      end
      check("rst_mid_quiet", 32'(vcnt), 32'd0);

      // Back-to-back: consume while the next request is already waiting
      do_accept(OP_DIV_W, 32'd100, 32'd7);
      wait_done("b2b_first", 0, 32'd14);
      @(negedge clk);
      dif.out_allowin = 1'b1;
      dif.div_req     = 1'b1;
      dif.div_op      = OP_MOD_W;
      dif.src1        = 32'hFFFFFF9C;
      dif.src2        = 32'd7;
      @(posedge clk);
      #1;
      dif.out_allowin = 1'b0;
      check("b2b_bubble", 32'(dif.busy), 32'd0);
      @(posedge clk);
      #1;
      dif.div_req = 1'b0;
      check("b2b_second_accept", 32'(dif.busy), 32'd1);
      wait_done("b2b_second", 0, 32'hFFFFFFFE);
      consume();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
